// File: rtl/wb_cipher_hub_pkg.sv
// Shared constants, register map and FSM state type for the wb_cipher_hub block.
// Optional CBC chaining is enabled with the WB_CIPHER_HUB_CBC_EN macro.
package wb_cipher_hub_pkg;

    localparam int unsigned BLOCK_W = 64;
    localparam int unsigned KEY_W   = 64;

    localparam logic [31:0] CH_STRIDE = 32'h20;

    localparam logic [4:0] OFS_KEY_LO  = 5'h00;
    localparam logic [4:0] OFS_KEY_HI  = 5'h04;
    localparam logic [4:0] OFS_DIN_LO  = 5'h08;
    localparam logic [4:0] OFS_DIN_HI  = 5'h0C;
    localparam logic [4:0] OFS_CTRL    = 5'h10;
    localparam logic [4:0] OFS_STATUS  = 5'h14;
    localparam logic [4:0] OFS_DOUT_LO = 5'h18;
    localparam logic [4:0] OFS_DOUT_HI = 5'h1C;

    localparam int unsigned CTRL_START   = 0;
    localparam int unsigned CTRL_DECRYPT = 1;
    localparam int unsigned CTRL_IRQ_EN  = 2;
    localparam int unsigned CTRL_CBC     = 3;

    localparam int unsigned STAT_PEND = 0;
    localparam int unsigned STAT_DONE = 1;
    localparam int unsigned STAT_ERR  = 2;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_t;

    function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = sel[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_cipher_hub_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, with wrap-around.
module rr_arbiter #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned IDX_W  = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);

    int unsigned j;
    logic [IDX_W-1:0] jj;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        jj  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            j  = (32'(ptr) + 32'(i)) % NUM_CH;
            jj = IDX_W'(j);
            if (!any && req[jj]) begin
                any     = 1'b1;
                gnt[jj] = 1'b1;
                idx     = jj;
            end
        end
    end

endmodule

// File: rtl/wb_cipher_hub.sv
// Wishbone front end sharing one 64-bit block-cipher engine between NUM_CH channels.
// Define WB_CIPHER_HUB_CBC_EN to add per-channel IV registers and CBC chaining.
module wb_cipher_hub
    import wb_cipher_hub_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_wb_cyc,
    input  logic               i_wb_stb,
    input  logic               i_wb_we,
    input  logic [3:0]         i_wb_sel,
    input  logic [31:0]        i_wb_addr,
    input  logic [31:0]        i_wb_data,
    output logic               o_wb_ack,
    output logic [31:0]        o_wb_data,
    output logic               o_irq,
    output logic               o_eng_valid,
    input  logic               i_eng_ready,
    output logic [KEY_W-1:0]   o_eng_key,
    output logic [BLOCK_W-1:0] o_eng_din,
    output logic               o_eng_decrypt,
    input  logic               i_eng_done,
    input  logic [BLOCK_W-1:0] i_eng_dout
);

    localparam int unsigned IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [31:0] WIN_SIZE = 32'(NUM_CH) * CH_STRIDE;
    localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);

    logic [KEY_W-1:0]   key_q  [NUM_CH];
    logic [BLOCK_W-1:0] din_q  [NUM_CH];
    logic [BLOCK_W-1:0] dout_q [NUM_CH];
    logic [NUM_CH-1:0]  decrypt_q, irq_en_q, pend_q, done_q, err_q, rd_cbc;
`ifdef WB_CIPHER_HUB_CBC_EN
    logic [BLOCK_W-1:0] iv_q [NUM_CH];
    logic [NUM_CH-1:0]  cbc_q;
    assign rd_cbc = cbc_q;
`else
    assign rd_cbc = '0;
`endif

    logic        wb_req, in_win, wb_wr;
    logic [31:0] wb_off, rdata;
    logic [2:0]  wb_ch;
    logic [4:0]  wb_reg;

    assign wb_req = i_wb_cyc & i_wb_stb & ~o_wb_ack;
    assign wb_off = i_wb_addr - BASE_ADDR;
    assign in_win = (i_wb_addr >= BASE_ADDR) && (wb_off < WIN_SIZE);
    assign wb_ch  = wb_off[7:5];
    assign wb_reg = {wb_off[4:2], 2'b00};
    assign wb_wr  = wb_req & i_wb_we & in_win;

    always_comb begin
        rdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (in_win && int'(wb_ch) == c) begin
                case (wb_reg)
                    OFS_KEY_LO:  rdata = key_q[c][31:0];
                    OFS_KEY_HI:  rdata = key_q[c][63:32];
                    OFS_DIN_LO:  rdata = din_q[c][31:0];
                    OFS_DIN_HI:  rdata = din_q[c][63:32];
                    OFS_CTRL:    rdata = {28'h0, rd_cbc[c], irq_en_q[c], decrypt_q[c], 1'b0};
                    OFS_STATUS:  rdata = {29'h0, err_q[c], done_q[c], pend_q[c]};
                    OFS_DOUT_LO: rdata = dout_q[c][31:0];
                    OFS_DOUT_HI: rdata = dout_q[c][63:32];
                    default:     rdata = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
            o_irq     <= 1'b0;
        end else begin
            o_wb_ack  <= wb_req;
            o_wb_data <= (wb_req && !i_wb_we) ? rdata : 32'h0;
            o_irq     <= |(done_q & irq_en_q);
        end
    end

    logic [NUM_CH-1:0]  arb_gnt, gnt_oh_q;
    logic [IDX_W-1:0]   arb_idx, ptr_q, gnt_q;
    logic               arb_any, eng_complete;
    logic [BLOCK_W-1:0] eng_din_sel;
    state_t             state_q;

    rr_arbiter #(
        .NUM_CH(NUM_CH),
        .IDX_W (IDX_W)
    ) u_arb (
        .req(pend_q),
        .ptr(ptr_q),
        .gnt(arb_gnt),
        .idx(arb_idx),
        .any(arb_any)
    );

`ifdef WB_CIPHER_HUB_CBC_EN
    assign eng_din_sel = (cbc_q[arb_idx] && !decrypt_q[arb_idx]) ?
                         (din_q[arb_idx] ^ iv_q[arb_idx]) : din_q[arb_idx];
`else
    assign eng_din_sel = din_q[arb_idx];
`endif

    assign eng_complete = (state_q == StWait) && i_eng_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            ptr_q         <= '0;
            gnt_q         <= '0;
            gnt_oh_q      <= '0;
            o_eng_valid   <= 1'b0;
            o_eng_key     <= '0;
            o_eng_din     <= '0;
            o_eng_decrypt <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: if (arb_any) begin
                    gnt_q         <= arb_idx;
                    gnt_oh_q      <= arb_gnt;
                    o_eng_valid   <= 1'b1;
                    o_eng_key     <= key_q[arb_idx];
                    o_eng_din     <= eng_din_sel;
                    o_eng_decrypt <= decrypt_q[arb_idx];
                    state_q       <= StIssue;
                end
                StIssue: if (i_eng_ready) begin
                    o_eng_valid <= 1'b0;
                    state_q     <= StWait;
                end
                StWait: if (i_eng_done) begin
                    ptr_q   <= (gnt_q == LAST_CH) ? '0 : gnt_q + IDX_W'(1);
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Completion is applied after the bus write so a same-cycle DONE set beats W1C.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                key_q[c]  <= '0;
                din_q[c]  <= '0;
                dout_q[c] <= '0;
`ifdef WB_CIPHER_HUB_CBC_EN
                iv_q[c]   <= '0;
`endif
            end
            decrypt_q <= '0;
            irq_en_q  <= '0;
            pend_q    <= '0;
            done_q    <= '0;
            err_q     <= '0;
`ifdef WB_CIPHER_HUB_CBC_EN
            cbc_q     <= '0;
`endif
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wb_wr && int'(wb_ch) == c) begin
                    case (wb_reg)
                        OFS_KEY_LO: if (pend_q[c]) err_q[c] <= 1'b1;
                            else key_q[c][31:0] <= apply_sel(key_q[c][31:0], i_wb_data, i_wb_sel);
                        OFS_KEY_HI: if (pend_q[c]) err_q[c] <= 1'b1;
                            else key_q[c][63:32] <= apply_sel(key_q[c][63:32], i_wb_data, i_wb_sel);
                        OFS_DIN_LO: if (pend_q[c]) err_q[c] <= 1'b1;
                            else din_q[c][31:0] <= apply_sel(din_q[c][31:0], i_wb_data, i_wb_sel);
                        OFS_DIN_HI: if (pend_q[c]) err_q[c] <= 1'b1;
                            else din_q[c][63:32] <= apply_sel(din_q[c][63:32], i_wb_data, i_wb_sel);
                        OFS_CTRL: if (pend_q[c]) err_q[c] <= 1'b1;
                            else if (i_wb_sel[0]) begin
                                decrypt_q[c] <= i_wb_data[CTRL_DECRYPT];
                                irq_en_q[c]  <= i_wb_data[CTRL_IRQ_EN];
`ifdef WB_CIPHER_HUB_CBC_EN
                                cbc_q[c]     <= i_wb_data[CTRL_CBC];
`endif
                                if (i_wb_data[CTRL_START]) begin
                                    pend_q[c] <= 1'b1;
                                    done_q[c] <= 1'b0;
                                end
                            end
                        OFS_STATUS: if (i_wb_sel[0]) begin
                            if (i_wb_data[STAT_DONE]) done_q[c] <= 1'b0;
                            if (i_wb_data[STAT_ERR])  err_q[c]  <= 1'b0;
                        end
`ifdef WB_CIPHER_HUB_CBC_EN
                        OFS_DOUT_LO: iv_q[c][31:0]  <= apply_sel(iv_q[c][31:0], i_wb_data, i_wb_sel);
                        OFS_DOUT_HI: iv_q[c][63:32] <= apply_sel(iv_q[c][63:32], i_wb_data, i_wb_sel);
`endif
                        default: ;
                    endcase
                end
                if (eng_complete && gnt_oh_q[c]) begin
                    pend_q[c] <= 1'b0;
                    done_q[c] <= 1'b1;
`ifdef WB_CIPHER_HUB_CBC_EN
                    if (cbc_q[c] && decrypt_q[c]) begin
                        dout_q[c] <= i_eng_dout ^ iv_q[c];
                        iv_q[c]   <= din_q[c];
                    end else begin
                        dout_q[c] <= i_eng_dout;
                        if (cbc_q[c]) iv_q[c] <= i_eng_dout;
                    end
`else
                    dout_q[c] <= i_eng_dout;
`endif
                end
            end
        end
    end

endmodule
